// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-side signal bundle for uart_tx_fifo.
// LEVEL and the DEPTH_LOG2 parameter exist only when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if
`ifdef UART_TX_FIFO_LEVEL_EN
  #(parameter int DEPTH_LOG2 = 4)
`endif
  ;

  // Handshake semantics:
  // - WR_EN is a one-cycle write strobe with no ready.
  //   A strobe seen while FULL=1 is dropped and latches OVERFLOW.
  // - TX_DV is a one-cycle launch toward uart_tx, carrying TX_BYTE.
  //   TX_BYTE then holds until the transmitter returns its one-cycle TX_DONE.
  logic       WR_EN;
  logic [7:0] WR_BYTE;
  logic       FULL;
  logic       EMPTY;
  logic       OVERFLOW;
  logic       TX_DV;
  logic [7:0] TX_BYTE;
  logic       TX_DONE;
  logic       BUSY;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [DEPTH_LOG2:0] LEVEL;

  modport master (
    output WR_EN, WR_BYTE, TX_DONE,
    input  FULL, EMPTY, OVERFLOW, TX_DV, TX_BYTE, BUSY, LEVEL
  );

  modport slave (
    input  WR_EN, WR_BYTE, TX_DONE,
    output FULL, EMPTY, OVERFLOW, TX_DV, TX_BYTE, BUSY, LEVEL
  );
`else
  modport master (
    output WR_EN, WR_BYTE, TX_DONE,
    input  FULL, EMPTY, OVERFLOW, TX_DV, TX_BYTE, BUSY
  );

  modport slave (
    input  WR_EN, WR_BYTE, TX_DONE,
    output FULL, EMPTY, OVERFLOW, TX_DV, TX_BYTE, BUSY
  );
`endif

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: queues writes and launches one byte per frame.
// Defining UART_TX_FIFO_LEVEL_EN adds the LEVEL occupancy output on the interface.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic          SER_CLK,
  input  logic          RST,
  uart_tx_fifo_if.slave bus,
  output logic          dbg_state
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_n;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;

  logic       full_q;
  logic       empty_q;
  logic       busy_q;
  logic       overflow_q;
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;

  logic wr_acc;
  logic drop;
  logic pop;
  logic tx_dv_n;
  logic full_n;
  logic empty_n;
  logic busy_n;

  always_comb begin
    state_n = state_q;
    pop     = 1'b0;
    tx_dv_n = 1'b0;
    wr_acc  = bus.WR_EN && !full_q;
    drop    = bus.WR_EN && full_q;

    case (state_q)
      IDLE: begin
        // TX_DONE is ignored here; only a non-empty queue starts a frame.
        if (!empty_q) begin
          pop     = 1'b1;
          tx_dv_n = 1'b1;
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.TX_DONE) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A pop never frees a slot for a write in the same cycle while FULL=1.
    case ({wr_acc, pop})
      2'b10:   cnt_n = cnt_q + CW'(1);
      2'b01:   cnt_n = cnt_q - CW'(1);
      default: cnt_n = cnt_q;
    endcase

    full_n  = (cnt_n == FULL_CNT);
    empty_n = (cnt_n == '0);
    busy_n  = (state_n == WAIT_DONE) || !empty_n;
  end

  always_ff @(posedge SER_CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      busy_q  <= busy_n;
      tx_dv_q <= tx_dv_n;
      if (wr_acc) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q      <= rd_q + PW'(1);
        tx_byte_q <= mem[rd_q];
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage carries no reset; cnt alone decides which entries are valid.
  always_ff @(posedge SER_CLK) begin
    if (!RST && wr_acc) begin
      mem[wr_q] <= bus.WR_BYTE;
    end
  end

  assign bus.FULL     = full_q;
  assign bus.EMPTY    = empty_q;
  assign bus.BUSY     = busy_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.TX_DV    = tx_dv_q;
  assign bus.TX_BYTE  = tx_byte_q;
`ifdef UART_TX_FIFO_LEVEL_EN
  assign bus.LEVEL    = cnt_q;
`endif

  assign dbg_state = state_q;

endmodule
